// File: rtl/ibex_md_sequencer_pkg.sv
// ibex_md_sequencer_pkg
//   Shared types and constants for the iterative multiply/divide sequencer.
//   md_op_e   : operation select (MULL, MULH, DIV, REM)
//   md_fsm_e  : sequencer state encoding
//   MD_SIGNED_A_BIT / MD_SIGNED_B_BIT : bit positions inside signed_mode
package ibex_md_sequencer_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_ABS  = 3'd1,
    MD_COMP = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_fsm_e;

  parameter int unsigned MD_SIGNED_A_BIT = 0;
  parameter int unsigned MD_SIGNED_B_BIT = 1;

endpackage

// File: rtl/ibex_md_addsub.sv
// ibex_md_addsub
//   (OpW+1)-bit adder/subtractor shared by the abs, iterate and sign-fix steps.
//   Ports:
//     a_i, b_i  in  OpW+1  operands
//     sub_i     in  1      1: a_i - b_i, 0: a_i + b_i
//     sum_o     out OpW+1  result, modulo 2^(OpW+1)
//     borrow_o  out 1      inverted carry out; for a subtract this is a_i < b_i
module ibex_md_addsub #(
  parameter int unsigned OpW = 32
) (
  input  logic [OpW:0] a_i,
  input  logic [OpW:0] b_i,
  input  logic         sub_i,
  output logic [OpW:0] sum_o,
  output logic         borrow_o
);

  logic [OpW+1:0] full;

  assign full     = {1'b0, a_i} + {1'b0, b_i ^ {(OpW+1){sub_i}}} + {{(OpW+1){1'b0}}, sub_i};
  assign sum_o    = full[OpW:0];
  assign borrow_o = ~full[OpW+1];

endmodule

// File: rtl/ibex_md_sequencer.sv
// ibex_md_sequencer
//   Iterative RV32M multiply/divide sequencer: abs -> OpW iterations -> sign fix,
//   all through one shared ibex_md_addsub.
//   Optional feature macro: IBEX_MD_DIV0_SHORTCUT_EN (DIV/REM by zero completes
//   straight from MD_IDLE to MD_DONE).
//   Ports:
//     clk_i, rst_i        clock, async active-high reset
//     req_i, operator_i   request and md_op_e operation
//     signed_mode_i       bit0 op_a signed, bit1 op_b signed
//     op_a_i, op_b_i      multiplicand/dividend, multiplier/divisor
//     kill_i              abort in-flight operation
//     ready_o             idle, request can be accepted
//     valid_o             one-cycle result strobe
//     result_o            result, held until the next result is produced
//
//   state   | meaning
//   MD_IDLE | waiting for a request
//   MD_ABS  | replace negative signed dividend/multiplicand by its magnitude
//   MD_COMP | one shift-add / restoring-divide step per cycle
//   MD_FIX  | apply sign, select and register the result
//   MD_DONE | valid_o strobe
module ibex_md_sequencer
  import ibex_md_sequencer_pkg::*;
#(
  parameter int unsigned OpW = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req_i,
  input  logic [1:0]     operator_i,
  input  logic [1:0]     signed_mode_i,
  input  logic [OpW-1:0] op_a_i,
  input  logic [OpW-1:0] op_b_i,
  input  logic           kill_i,
  output logic           ready_o,
  output logic           valid_o,
  output logic [OpW-1:0] result_o
);

  localparam int unsigned CntW = $clog2(OpW);

  md_fsm_e          state_q, state_d;
  md_op_e           op_q, op_d;
  logic [1:0]       sign_q, sign_d;
  logic [OpW-1:0]   op_b_q, op_b_d;
  logic [2*OpW-1:0] acc_q, acc_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OpW-1:0]   result_q, result_d;

  logic [OpW:0]     add_a, add_b, add_sum;
  logic             add_sub, add_borrow;

  logic [OpW-1:0]   acc_hi, acc_lo;
  logic [OpW:0]     b_ext, shifted;
  logic [OpW-1:0]   fix_val;
  logic             q_bit;
  logic             negate;

  // acc holds {partial product high, remaining multiplier bits} for multiplies
  // and {partial remainder, dividend/quotient bits} for divides.
  assign acc_hi  = acc_q[2*OpW-1:OpW];
  assign acc_lo  = acc_q[OpW-1:0];
  // op_b is never converted to a magnitude; a negative divisor/multiplier is
  // handled by flipping add/subtract, so b_ext is its sign-extended value.
  assign b_ext   = {neg_b_q, op_b_q};
  assign shifted = {acc_hi, acc_lo[OpW-1]};

  ibex_md_addsub #(.OpW(OpW)) u_addsub (
    .a_i      (add_a),
    .b_i      (add_b),
    .sub_i    (add_sub),
    .sum_o    (add_sum),
    .borrow_o (add_borrow)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_d   = sign_q;
    op_b_d   = op_b_q;
    acc_d    = acc_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    add_a    = '0;
    add_b    = '0;
    add_sub  = 1'b0;
    fix_val  = '0;
    q_bit    = 1'b0;
    negate   = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (req_i && !kill_i) begin
          op_d    = md_op_e'(operator_i);
          sign_d  = signed_mode_i;
          op_b_d  = op_b_i;
          acc_d   = {{OpW{1'b0}}, op_a_i};
          state_d = MD_ABS;
`ifdef IBEX_MD_DIV0_SHORTCUT_EN
          if (operator_i[1] && (op_b_i == '0)) begin
            state_d  = MD_DONE;
            result_d = (md_op_e'(operator_i) == MD_OP_DIV) ? '1 : op_a_i;
          end
`else
`endif
        end
      end

      MD_ABS: begin
        neg_a_d = sign_q[MD_SIGNED_A_BIT] & acc_lo[OpW-1];
        neg_b_d = sign_q[MD_SIGNED_B_BIT] & op_b_q[OpW-1];
        add_a   = '0;
        add_b   = {acc_lo[OpW-1], acc_lo};
        add_sub = 1'b1;
        // -2^(OpW-1) negates to itself, which read unsigned is its magnitude.
        if (neg_a_d) acc_d = {{OpW{1'b0}}, add_sum[OpW-1:0]};
        cnt_d   = CntW'(OpW - 1);
        state_d = MD_COMP;
      end

      MD_COMP: begin
        if (!op_q[1]) begin
          // Shift-add of |b|: subtracting a negative b adds its magnitude.
          add_a   = {1'b0, acc_hi};
          add_b   = acc_q[0] ? b_ext : '0;
          add_sub = neg_b_q;
          acc_d   = {add_sum, acc_q[OpW-1:1]};
        end else begin
          // Restoring step: shifted - |b|, adding b when it is negative.
          // The carry out equals shifted >= |b| in both cases.
          add_a   = shifted;
          add_b   = b_ext;
          add_sub = ~neg_b_q;
          q_bit   = ~add_borrow;
          acc_d   = {(q_bit ? add_sum[OpW-1:0] : shifted[OpW-1:0]), acc_lo[OpW-2:0], q_bit};
        end
        if (cnt_q == '0) begin
          state_d = MD_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      MD_FIX: begin
        unique case (op_q)
          MD_OP_MULL: begin
            negate  = neg_a_q ^ neg_b_q;
            fix_val = acc_lo;
          end
          MD_OP_MULH: begin
            negate  = 1'b0;
            fix_val = acc_hi;
          end
          MD_OP_DIV: begin
            negate  = (neg_a_q ^ neg_b_q) && (op_b_q != '0);
            fix_val = acc_lo;
          end
          default: begin
            negate  = neg_a_q;
            fix_val = acc_hi;
          end
        endcase

        if ((op_q == MD_OP_MULH) && (neg_a_q ^ neg_b_q)) begin
          // High half of the negated 2*OpW product: ~hi plus the carry that
          // propagates out of -lo only when lo is zero.
          add_a = {1'b0, ~acc_hi};
          add_b = {{OpW{1'b0}}, (acc_lo == '0)};
        end else if (negate) begin
          add_a   = '0;
          add_b   = {1'b0, fix_val};
          add_sub = 1'b1;
        end else begin
          add_a = {1'b0, fix_val};
        end
        result_d = add_sum[OpW-1:0];
        state_d  = MD_DONE;
      end

      MD_DONE: begin
        state_d = MD_IDLE;
      end

      default: begin
        state_d = MD_IDLE;
      end
    endcase

    if (kill_i && (state_q != MD_IDLE)) begin
      state_d  = MD_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_OP_MULL;
      sign_q   <= '0;
      op_b_q   <= '0;
      acc_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      op_b_q   <= op_b_d;
      acc_q    <= acc_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == MD_IDLE);
  assign valid_o  = (state_q == MD_DONE) && !kill_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_ibex_md_sequencer.sv
module tb_ibex_md_sequencer;
  import ibex_md_sequencer_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic [1:0]  operator_i = 2'b00;
  logic [1:0]  signed_mode_i = 2'b00;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        kill_i = 1'b0;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

`ifdef IBEX_MD_DIV0_SHORTCUT_EN
  localparam int Div0Lat = 1;
`else
  localparam int Div0Lat = 35;
`endif

  ibex_md_sequencer #(.OpW(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .operator_i    (operator_i),
    .signed_mode_i (signed_mode_i),
    .op_a_i        (op_a_i),
    .op_b_i        (op_b_i),
    .kill_i        (kill_i),
    .ready_o       (ready_o),
    .valid_o       (valid_o),
    .result_o      (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [1:0] mode,
                                         input logic [31:0] a, input logic [31:0] b);
    longint xa, xb, p;
    xa = mode[0] ? {{32{a[31]}}, a} : {32'h0, a};
    xb = mode[1] ? {{32{b[31]}}, b} : {32'h0, b};
    p  = 0;
    case (op)
      2'd0: begin p = xa * xb; return p[31:0]; end
      2'd1: begin p = xa * xb; return p[63:32]; end
      2'd2: begin if (b == 0) return 32'hFFFF_FFFF; p = xa / xb; return p[31:0]; end
      default: begin if (b == 0) return a; p = xa % xb; return p[31:0]; end
    endcase
  endfunction

  // Issue one request (waiting for ready_o), then wait for valid_o.
  // lat is the number of cycles from the accept cycle to the valid cycle.
  task automatic do_op(input logic [1:0] op, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    operator_i    = op;
    signed_mode_i = mode;
    op_a_i        = a;
    op_b_i        = b;
    req_i         = 1'b1;
    for (int i = 0; i < 64 && !ready_o; i++) begin
      @(posedge clk_i); #1;
    end
    @(posedge clk_i); #1;
    req_i = 1'b0;
    lat   = -1;
    res   = 'x;
    for (int n = 1; n <= 64 && lat < 0; n++) begin
      if (valid_o) begin
        lat = n;
        res = result_o;
        chk("ready_valid_exclusive", {31'b0, ready_o}, 32'd0);
      end else begin
        @(posedge clk_i); #1;
      end
    end
  endtask

  logic [31:0] res, exp_v;
  int          lat, exp_lat;
  logic        saw_valid;
  logic [1:0]  r_op, r_mode;
  logic [31:0] r_a, r_b;

  initial begin
    #2;
    chk("reset_ready", {31'b0, ready_o}, 32'd1);
    chk("reset_valid", {31'b0, valid_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    do_op(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, res, lat);
    chk("mulh_min_min", res, 32'h4000_0000);
    chk("mulh_latency", lat, 32'd35);
    do_op(MD_OP_MULL, 2'b11, 32'h8000_0000, 32'h8000_0000, res, lat);
    chk("mull_min_min", res, 32'h0000_0000);

    do_op(MD_OP_DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    chk("div_overflow", res, 32'h8000_0000);
    chk("div_latency", lat, 32'd35);
    do_op(MD_OP_REM, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    chk("rem_overflow", res, 32'h0000_0000);

    do_op(MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'h0, res, lat);
    chk("div_by_zero", res, 32'hFFFF_FFFF);
    chk("div_by_zero_latency", lat, Div0Lat);
    do_op(MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'h0, res, lat);
    chk("rem_by_zero", res, 32'hFFFF_FFF9);
    chk("rem_by_zero_latency", lat, Div0Lat);

    do_op(MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    chk("mulhsu_neg1", res, 32'hFFFF_FFFF);
    do_op(MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'h2, res, lat);
    chk("rem_neg7_2", res, 32'hFFFF_FFFF);

    // Kill at T+10 of a DIV; last result was 0xFFFFFFFF.
    operator_i    = MD_OP_DIV;
    signed_mode_i = 2'b00;
    op_a_i        = 32'd100;
    op_b_i        = 32'd7;
    req_i         = 1'b1;
    @(posedge clk_i); #1;
    req_i     = 1'b0;
    saw_valid = 1'b0;
    repeat (9) begin
      @(posedge clk_i); #1;
      if (valid_o) saw_valid = 1'b1;
    end
    kill_i = 1'b1;
    if (valid_o) saw_valid = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    chk("kill_ready", {31'b0, ready_o}, 32'd1);
    chk("kill_no_valid", {31'b0, saw_valid | valid_o}, 32'd0);
    chk("kill_result_held", result_o, 32'hFFFF_FFFF);
    do_op(MD_OP_MULL, 2'b00, 32'd3, 32'd5, res, lat);
    chk("mull_3x5_after_kill", res, 32'd15);
    chk("mull_3x5_latency", lat, 32'd35);

    // Back-to-back random operations against the reference model.
    for (int k = 0; k < 6; k++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_mode = ($urandom_range(0, 2) == 2) ? 2'b11 : 2'($urandom_range(0, 1));
      r_a    = $urandom;
      r_b    = (k == 3) ? 32'($urandom_range(1, 9)) : $urandom;
      if (k == 4) r_b = 32'hFFFF_FFFF;
      exp_v  = ref_md(r_op, r_mode, r_a, r_b);
      do_op(r_op, r_mode, r_a, r_b, res, lat);
      chk("random_result", res, exp_v);
      exp_lat = 35;
      chk("random_latency", lat, exp_lat);
    end

    // Reset in the middle of MD_COMP.
    operator_i    = MD_OP_DIV;
    signed_mode_i = 2'b11;
    op_a_i        = 32'd1000;
    op_b_i        = 32'd3;
    req_i         = 1'b1;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    chk("midreset_ready", {31'b0, ready_o}, 32'd1);
    chk("midreset_valid", {31'b0, valid_o}, 32'd0);
    chk("midreset_result", result_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    do_op(MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    chk("mulhu_max_after_reset", res, 32'hFFFF_FFFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
